// File: rtl/reaction_timer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reaction_timer_ctrl_pkg
// Description : Shared constants for the reaction-timer controller and the
//               7-segment display driver that consumes its results.
// Revision    : 1.0 - initial release
// ============================================================================
package reaction_timer_ctrl_pkg;

  // Width of reaction_ms / best_ms, shared with the display driver
  localparam int RESULT_W = 14;

  // best_ms value meaning "no valid reaction recorded yet"
  localparam logic [RESULT_W-1:0] BEST_NONE = 14'h3FFF;

  // FSM state encoding
  localparam int          STATE_W  = 3;
  localparam logic [2:0]  ST_IDLE  = 3'd0;
  localparam logic [2:0]  ST_WAIT  = 3'd1;
  localparam logic [2:0]  ST_GO    = 3'd2;
  localparam logic [2:0]  ST_DONE  = 3'd3;
  localparam logic [2:0]  ST_FOUL  = 3'd4;

  // Smaller of two millisecond counts
  function automatic logic [RESULT_W-1:0] min_ms(input logic [RESULT_W-1:0] a,
                                                 input logic [RESULT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reaction_timer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : reaction_timer_ctrl_if
// Description : Button/tick inputs and display-side outputs of the
//               reaction-timer controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface reaction_timer_ctrl_if;
  import reaction_timer_ctrl_pkg::*;

  logic                tick_1ms;
  logic                start;
  logic                react;
  logic                go_led;
  logic                busy;
  logic                foul;
  logic                timeout;
  logic                result_valid;
  logic [RESULT_W-1:0] reaction_ms;
  logic [RESULT_W-1:0] best_ms;

  // Front end / stimulus side
  modport master (
    output tick_1ms, start, react,
    input  go_led, busy, foul, timeout, result_valid, reaction_ms, best_ms
  );

  // Controller side
  modport slave (
    input  tick_1ms, start, react,
    output go_led, busy, foul, timeout, result_valid, reaction_ms, best_ms
  );

endinterface
`default_nettype wire

// File: rtl/reaction_timer_ctrl_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : lfsr16
// Description : Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  // Shift left, feeding back the XOR of the tap bits
  always_comb begin
    q_d = {q_q[14:0], q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10]};
  end

  // Generator register; runs every clock regardless of controller state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= SEED;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/reaction_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reaction_timer_ctrl
// Description : Reaction-timer sequencer: random pre-delay, go stimulus,
//               millisecond reaction measurement, foul/timeout detection
//               and best-score tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module reaction_timer_ctrl
  import reaction_timer_ctrl_pkg::*;
#(
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          RAND_BITS    = 10,
  parameter int          MAX_MS       = 9999,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  reaction_timer_ctrl_if.slave  bus
);

  localparam logic [15:0]         C_MIN_DELAY = 16'(MIN_DELAY_MS);
  localparam logic [15:0]         C_RAND_MASK = 16'((1 << RAND_BITS) - 1);
  localparam logic [RESULT_W-1:0] C_MAX_MS    = RESULT_W'(MAX_MS);

  logic [15:0]          lfsr;
  logic [STATE_W-1:0]   state_q, state_d;
  logic [15:0]          delay_cnt_q, delay_cnt_d;
  logic [RESULT_W-1:0]  ms_cnt_q, ms_cnt_d;
  logic                 go_led_q, go_led_d;
  logic                 busy_q, busy_d;
  logic                 foul_q, foul_d;
  logic                 timeout_q, timeout_d;
  logic                 result_valid_q, result_valid_d;
  logic [RESULT_W-1:0]  reaction_ms_q, reaction_ms_d;
  logic [RESULT_W-1:0]  best_ms_q, best_ms_d;
  logic [RESULT_W-1:0]  ms_inc;
  logic                 delay_expire;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr)
  );

  assign ms_inc       = ms_cnt_q + 1'b1;
  assign delay_expire = bus.tick_1ms && (delay_cnt_q == 16'd1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; react beats a simultaneous tick in WAIT and GO
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FOUL: if (bus.start) state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.react)       state_d = ST_FOUL;
        else if (delay_expire) state_d = ST_GO;
      end
      ST_GO: begin
        if (bus.react)                                state_d = ST_DONE;
        else if (bus.tick_1ms && ms_inc == C_MAX_MS)  state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter and result updates; go_led/busy follow the next state so they
  // switch together with the registered results
  always_comb begin
    delay_cnt_d    = delay_cnt_q;
    ms_cnt_d       = ms_cnt_q;
    foul_d         = foul_q;
    timeout_d      = timeout_q;
    result_valid_d = 1'b0;
    reaction_ms_d  = reaction_ms_q;
    best_ms_d      = best_ms_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FOUL: begin
        if (bus.start) begin
          delay_cnt_d = C_MIN_DELAY + (lfsr & C_RAND_MASK);
          foul_d      = 1'b0;
          timeout_d   = 1'b0;
        end
      end
      ST_WAIT: begin
        if (bus.react) begin
          foul_d = 1'b1;
        end else if (bus.tick_1ms) begin
          if (delay_expire) ms_cnt_d    = '0;
          else              delay_cnt_d = delay_cnt_q - 16'd1;
        end
      end
      ST_GO: begin
        if (bus.react) begin
          reaction_ms_d  = ms_cnt_q;
          result_valid_d = 1'b1;
          best_ms_d      = min_ms(best_ms_q, ms_cnt_q);
        end else if (bus.tick_1ms) begin
          if (ms_inc == C_MAX_MS) begin
            timeout_d      = 1'b1;
            reaction_ms_d  = C_MAX_MS;
            result_valid_d = 1'b1;
          end else begin
            ms_cnt_d = ms_inc;
          end
        end
      end
      default: ;
    endcase
    go_led_d = (state_d == ST_GO);
    busy_d   = (state_d == ST_WAIT) || (state_d == ST_GO);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_cnt_q    <= '0;
      ms_cnt_q       <= '0;
      go_led_q       <= 1'b0;
      busy_q         <= 1'b0;
      foul_q         <= 1'b0;
      timeout_q      <= 1'b0;
      result_valid_q <= 1'b0;
      reaction_ms_q  <= '0;
      best_ms_q      <= BEST_NONE;
    end else begin
      delay_cnt_q    <= delay_cnt_d;
      ms_cnt_q       <= ms_cnt_d;
      go_led_q       <= go_led_d;
      busy_q         <= busy_d;
      foul_q         <= foul_d;
      timeout_q      <= timeout_d;
      result_valid_q <= result_valid_d;
      reaction_ms_q  <= reaction_ms_d;
      best_ms_q      <= best_ms_d;
    end
  end

  assign bus.go_led       = go_led_q;
  assign bus.busy         = busy_q;
  assign bus.foul         = foul_q;
  assign bus.timeout      = timeout_q;
  assign bus.result_valid = result_valid_q;
  assign bus.reaction_ms  = reaction_ms_q;
  assign bus.best_ms      = best_ms_q;

endmodule
`default_nettype wire
